// File: rtl/receiver_pkg.sv
// Shared definitions for the receiver: FSM state encoding and the default
// word/frame geometry shared with the upstream sender.
package receiver_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_e;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT = 16;

endpackage

// File: rtl/rx_buffer.sv
// DEPTH x WIDTH capture storage: one synchronous write port and one
// registered read port with read-before-write behaviour on collisions.
module rx_buffer
  import receiver_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage is deliberately reset so a fresh capture buffer reads
  // back all zeros; this forces flops instead of a RAM macro, which is only
  // acceptable because the buffer is one frame deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/receiver.sv
// Request/Ack word receiver: captures one word per handshake into a circular
// frame buffer and reports per-frame word count and frame completion.
module receiver
  import receiver_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Request,
  input  logic [WIDTH-1:0]  sdrDataIn,
  output logic              Ack,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData,
  output logic [ADDR_W:0]   wordCount,
  output logic              frameDone,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic                ack_q;
  logic                frame_done_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     word_count_q;
  logic                we_d;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    we_d = 1'b0;
    if (!clear && state_q == S_IDLE && Request) we_d = 1'b1;
  end

  // NOTE: state uses non-blocking assignments only, so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (clear) begin
        // A Request still high at clear must not be captured again.
        ack_q        <= 1'b0;
        wr_ptr_q     <= '0;
        word_count_q <= '0;
        state_q      <= Request ? S_WAIT_LOW : S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (Request) begin
              ack_q   <= 1'b1;
              state_q <= S_ACK;
            end
          end
          S_ACK: begin
            ack_q    <= 1'b0;
            wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (word_count_q == LAST_CNT) begin
              frame_done_q <= 1'b1;
              word_count_q <= FULL_CNT;
            end else if (word_count_q == FULL_CNT) begin
              word_count_q <= (ADDR_W + 1)'(1);
            end else begin
              word_count_q <= word_count_q + 1'b1;
            end
            state_q <= S_WAIT_LOW;
          end
          S_WAIT_LOW: begin
            if (!Request) state_q <= S_IDLE;
          end
          default: begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  rx_buffer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rx_buffer (
    .clk     (clk),
    .rst_n   (Reset),
    .we_i    (we_d),
    .waddr_i (wr_ptr_q),
    .wdata_i (sdrDataIn),
    .raddr_i (rdAddr),
    .rdata_o (rdData)
  );

  assign Ack       = ack_q;
  assign frameDone = frame_done_q;
  assign wordCount = word_count_q;
  assign busy      = (state_q == S_ACK) || (state_q == S_WAIT_LOW);

endmodule

// File: tb/tb_receiver.sv
// Randomized self-checking bench for receiver against a frame-buffer model
// kept as a plain array, write pointer and word count.
module tb_receiver;
  import receiver_pkg::*;

  localparam int WIDTH  = WIDTH_DEFAULT;
  localparam int DEPTH  = DEPTH_DEFAULT;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              Reset;
  logic              Request;
  logic [WIDTH-1:0]  sdrDataIn;
  logic              Ack;
  logic              clear;
  logic [ADDR_W-1:0] rdAddr;
  logic [WIDTH-1:0]  rdData;
  logic [ADDR_W:0]   wordCount;
  logic              frameDone;
  logic              busy;

  receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Request   (Request),
    .sdrDataIn (sdrDataIn),
    .Ack       (Ack),
    .clear     (clear),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .wordCount (wordCount),
    .frameDone (frameDone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  int ref_ptr;
  int ref_count;
  int ref_frames = 0;

  always @(negedge clk) if (Reset === 1'b1 && frameDone === 1'b1) fd_seen++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr   = 0;
    ref_count = 0;
  endtask

  task automatic read_check(input int addr, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    rdAddr = addr[ADDR_W-1:0];
    @(negedge clk);
    check($sformatf("rd_data[%0d]", addr), rdData, exp);
  endtask

  task automatic read_all();
    for (int k = 0; k < DEPTH; k++) read_check(k, ref_mem[k]);
  endtask

  task automatic clear_idle();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ref_ptr   = 0;
    ref_count = 0;
    check("clear_count", wordCount, 0);
  endtask

  // One full handshake; the read port watches the write address to prove
  // that a same-cycle read returns the pre-write contents.
  task automatic send_word(input logic [WIDTH-1:0] data, input int hold);
    int lat;
    logic [WIDTH-1:0] old;
    @(negedge clk);
    check("idle_busy", busy, 0);
    old       = ref_mem[ref_ptr];
    Request   = 1'b1;
    sdrDataIn = data;
    rdAddr    = ref_ptr[ADDR_W-1:0];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (Ack !== 1'b1 && lat < 8);
    check("ack_latency", lat, 1);
    if (Ack !== 1'b1) begin
      Request = 1'b0;
      return;
    end
    check("collision_old_data", rdData, old);
    check("ack_busy", busy, 1);
    sdrDataIn = WIDTH'($urandom);
    ref_mem[ref_ptr] = data;
    ref_ptr   = (ref_ptr + 1) % DEPTH;
    ref_count = (ref_count == DEPTH) ? 1 : ref_count + 1;
    if (ref_count == DEPTH) ref_frames++;
    @(negedge clk);
    check("ack_one_cycle", Ack, 0);
    check("word_count", wordCount, ref_count);
    check("frame_done", frameDone, (ref_count == DEPTH));
    repeat (hold) begin
      @(negedge clk);
      sdrDataIn = WIDTH'($urandom);
      check("no_second_ack", Ack, 0);
      check("held_count", wordCount, ref_count);
    end
    Request = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    logic [WIDTH-1:0] data;

    Reset = 1'b0; Request = 1'b0; clear = 1'b0; rdAddr = '0; sdrDataIn = '0;
    ref_reset();
    repeat (5) @(negedge clk);
    check("reset_ack", Ack, 0);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_ack", Ack, 0);
    check("rst_count", wordCount, 0);
    check("rst_frame_done", frameDone, 0);
    check("rst_busy", busy, 0);
    read_all();

    // Single word with Request held long after Ack.
    send_word(16'hA5A5, 4);
    check("single_count", wordCount, 1);
    read_check(0, 16'hA5A5);

    // Full frame from address 0.
    clear_idle();
    fd0 = fd_seen;
    for (int i = 0; i < DEPTH; i++) send_word(16'h1000 + 16'(i), $urandom_range(0, 2));
    repeat (2) @(negedge clk);
    check("frame1_count", wordCount, DEPTH);
    check("frame1_done_pulses", fd_seen - fd0, 1);
    read_all();

    // Second frame overwrites in place; count restarts at 1.
    for (int k = 0; k < DEPTH; k++) begin
      send_word(16'h2000 + 16'(k), $urandom_range(0, 2));
      if (k == 0) check("wrap_count", wordCount, 1);
    end
    repeat (2) @(negedge clk);
    check("frame2_done_pulses", fd_seen - fd0, 2);
    read_all();

    // Random traffic with interleaved reads.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        read_check(a, ref_mem[a]);
      end
      send_word(WIDTH'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("total_frames", fd_seen, ref_frames);

    // clear while in ACK after five words.
    clear_idle();
    for (int i = 0; i < 5; i++) send_word(WIDTH'($urandom), 0);
    @(negedge clk);
    data = WIDTH'($urandom);
    Request = 1'b1;
    sdrDataIn = data;
    @(negedge clk);
    check("ack_before_clear", Ack, 1);
    clear = 1'b1;
    ref_mem[ref_ptr] = data;
    @(negedge clk);
    clear = 1'b0;
    ref_ptr   = 0;
    ref_count = 0;
    check("clear_ack_low", Ack, 0);
    check("clear_in_ack_count", wordCount, 0);
    check("clear_wait_low_busy", busy, 1);
    repeat (2) begin
      @(negedge clk);
      check("clear_no_recapture", Ack, 0);
      check("clear_still_waiting", busy, 1);
    end
    Request = 1'b0;
    send_word(16'h5EED, 1);
    read_all();

    // Reset while Ack is high.
    @(negedge clk);
    Request = 1'b1;
    sdrDataIn = WIDTH'($urandom);
    @(negedge clk);
    check("ack_before_reset", Ack, 1);
    #1 Reset = 1'b0;
    #1;
    check("async_reset_ack", Ack, 0);
    check("async_reset_count", wordCount, 0);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    Request = 1'b0;
    Reset   = 1'b1;
    ref_reset();
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
